// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit multiplexed 7-segment display between three requesters.
// Ownership is re-decided only at frame boundaries (fixed priority, req[0] highest),
// with a minimum hold time before a higher-priority requester may preempt.
// The displayed frame is an atomic snapshot taken at the same boundary.
module seg_display_arbiter #(
    parameter int unsigned CLK_DIV     = 65536,
    parameter int unsigned HOLD_FRAMES = 2,
    parameter logic [7:0]  IDLE_PAT    = 8'hB6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [95:0] seg_data,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        frame_start
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHold = 2'd1;
    localparam logic [1:0] StOpen = 2'd2;

    logic [PW-1:0] prescaler_q;
    logic [1:0]    digit_q;
    logic          tick;
    logic          fb;

    logic [1:0]    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    fbuf_q [4];
    logic [7:0]    fbuf_d [4];

    logic [2:0]    win_oh;
    logic          owner_req;

    assign tick = (prescaler_q == PRESC_MAX);
    // Frame boundary: last prescaler cycle of the rightmost digit.
    assign fb   = tick && (digit_q == 2'd3);

    assign grant = grant_q;
    assign busy  = |grant_q;

    // Digit-slot prescaler and digit scan counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            digit_q     <= 2'd0;
        end else begin
            prescaler_q <= tick ? '0 : prescaler_q + 1'b1;
            if (tick) begin
                digit_q <= digit_q + 2'd1;
            end
        end
    end

    // Fixed-priority winner and whether the current owner still requests.
    always_comb begin
        win_oh = 3'b000;
        if (req[0]) begin
            win_oh = 3'b001;
        end else if (req[1]) begin
            win_oh = 3'b010;
        end else if (req[2]) begin
            win_oh = 3'b100;
        end
        owner_req = |(req & grant_q);
    end

    // Ownership FSM next state, evaluated every cycle but committed only at fb.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = win_oh;
                    hold_d  = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!owner_req) begin
                    // Owner released: the remaining requests compete right away.
                    if (|req) begin
                        grant_d = win_oh;
                        hold_d  = '0;
                        state_d = StHold;
                    end else begin
                        grant_d = 3'b000;
                        hold_d  = '0;
                        state_d = StIdle;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    state_d = StOpen;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StOpen: begin
                if (!(|req)) begin
                    grant_d = 3'b000;
                    hold_d  = '0;
                    state_d = StIdle;
                end else if (win_oh != grant_q) begin
                    grant_d = win_oh;
                    hold_d  = '0;
                    state_d = StHold;
                end
            end
            default: begin
                grant_d = 3'b000;
                hold_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Snapshot source follows the owner chosen for the coming frame.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            fbuf_d[d] = IDLE_PAT;
            case (grant_d)
                3'b001:  fbuf_d[d] = seg_data[8*d +: 8];
                3'b010:  fbuf_d[d] = seg_data[32 + 8*d +: 8];
                3'b100:  fbuf_d[d] = seg_data[64 + 8*d +: 8];
                default: fbuf_d[d] = IDLE_PAT;
            endcase
        end
    end

    // Arbitration state and frame buffer update atomically at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 3'b000;
            hold_q  <= '0;
            for (int d = 0; d < 4; d++) begin
                fbuf_q[d] <= IDLE_PAT;
            end
        end else if (fb) begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            for (int d = 0; d < 4; d++) begin
                fbuf_q[d] <= fbuf_d[d];
            end
        end
    end

    // Registered pin drivers; one cycle behind the scan counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 4'b1111;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            an          <= ~(4'b1000 >> digit_q);
            seg         <= fbuf_q[digit_q];
            frame_start <= fb;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with CLK_DIV=4, HOLD_FRAMES=2 (16-cycle frames).
// Each frame window pushes the expected per-cycle pins, then steps and pops/compares.
module tb_seg_display_arbiter;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned HOLD_FRAMES = 2;
    localparam int          FRAME       = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req;
    logic [95:0] seg_data;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [2:0]  grant;
    logic        busy;
    logic        frame_start;

    seg_display_arbiter #(
        .CLK_DIV    (CLK_DIV),
        .HOLD_FRAMES(HOLD_FRAMES),
        .IDLE_PAT   (8'hB6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .seg_data   (seg_data),
        .an         (an),
        .seg        (seg),
        .grant      (grant),
        .busy       (busy),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [2:0] grant;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Expected state carried between frame windows.
    logic [2:0] prev_g;
    logic [7:0] prev_pat [4];

    localparam logic [95:0] DATA_A = {32'h86C7C0C1, 32'hB0A4F9C0, 32'h8092F8A4};
    localparam logic [95:0] DATA_B = {32'h86C7C0C1, 32'hB0A4F9C0, 32'h8882C6A1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] pat_of(input logic [95:0] data, input logic [2:0] g,
                                          input int d);
        case (g)
            3'b001:  return data[8*d +: 8];
            3'b010:  return data[32 + 8*d +: 8];
            3'b100:  return data[64 + 8*d +: 8];
            default: return 8'hB6;
        endcase
    endfunction

    // Window cycle i (1..16) follows the i-th rising edge after the previous boundary.
    task automatic push_window(input int n, input logic [2:0] eg);
        for (int i = 1; i <= n; i++) begin
            exp_t e;
            int   d;
            d       = (i - 1) / 4;
            e.an    = ~(4'b1000 >> d);
            e.seg   = prev_pat[d];
            e.grant = (i == FRAME) ? eg : prev_g;
            e.fs    = (i == FRAME);
            sb.push_back(e);
        end
    endtask

    task automatic step_check(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({tag, "_an"},    32'(an),          32'(e.an));
            check_eq({tag, "_seg"},   32'(seg),         32'(e.seg));
            check_eq({tag, "_grant"}, 32'(grant),       32'(e.grant));
            check_eq({tag, "_busy"},  32'(busy),        32'(|e.grant));
            check_eq({tag, "_fs"},    32'(frame_start), 32'(e.fs));
        end
    endtask

    // One frame: r0/d0 for the first half, r1/d1 from cycle 9 (sampled at the boundary).
    task automatic run_frame(input string tag, input logic [2:0] r0, input logic [95:0] d0,
                             input logic [2:0] r1, input logic [95:0] d1,
                             input logic [2:0] eg);
        req      = r0;
        seg_data = d0;
        push_window(FRAME, eg);
        for (int i = 1; i <= FRAME; i++) begin
            if (i == 9) begin
                req      = r1;
                seg_data = d1;
            end
            step_check(tag);
        end
        prev_g = eg;
        for (int d = 0; d < 4; d++) begin
            prev_pat[d] = pat_of(d1, eg, d);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check_eq({tag, "_an"},    32'(an),          32'h0000000F);
        check_eq({tag, "_seg"},   32'(seg),         32'h000000FF);
        check_eq({tag, "_grant"}, 32'(grant),       32'd0);
        check_eq({tag, "_busy"},  32'(busy),        32'd0);
        check_eq({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    task automatic clear_model();
        prev_g = 3'b000;
        for (int d = 0; d < 4; d++) begin
            prev_pat[d] = 8'hB6;
        end
    endtask

    initial begin
        req      = 3'b000;
        seg_data = DATA_A;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_pins("rst");
        rst_n = 1'b1;

        // Idle scan, then requester 1 takes the display.
        run_frame("idle",    3'b000, DATA_A, 3'b000, DATA_A, 3'b000);
        run_frame("req1",    3'b010, DATA_A, 3'b010, DATA_A, 3'b010);
        // Higher priority req[0] waits out the hold, wins once open.
        run_frame("hold_a",  3'b011, DATA_A, 3'b011, DATA_A, 3'b010);
        run_frame("hold_b",  3'b011, DATA_A, 3'b011, DATA_A, 3'b010);
        run_frame("preempt", 3'b011, DATA_A, 3'b011, DATA_A, 3'b001);
        run_frame("own0",    3'b001, DATA_A, 3'b001, DATA_A, 3'b001);
        // Owner data changes mid-frame: visible only from the next frame.
        run_frame("midchg",  3'b001, DATA_A, 3'b001, DATA_B, 3'b001);
        run_frame("newdat",  3'b001, DATA_B, 3'b001, DATA_B, 3'b001);
        // Owner drops while another is in HOLD; nobody else -> idle.
        run_frame("take2",   3'b100, DATA_B, 3'b100, DATA_B, 3'b100);
        run_frame("drop",    3'b000, DATA_B, 3'b000, DATA_B, 3'b000);
        // Release and new request at the same boundary.
        run_frame("re2",     3'b100, DATA_B, 3'b100, DATA_B, 3'b100);
        run_frame("swap",    3'b010, DATA_B, 3'b010, DATA_B, 3'b010);
        run_frame("h1",      3'b010, DATA_B, 3'b010, DATA_B, 3'b010);
        run_frame("open1",   3'b010, DATA_B, 3'b010, DATA_B, 3'b010);
        // req[0] pulse that ends before the boundary is never seen.
        run_frame("pulse",   3'b011, DATA_B, 3'b010, DATA_B, 3'b010);
        run_frame("rel",     3'b000, DATA_B, 3'b000, DATA_B, 3'b000);

        // Reset while digit 2 is being shown.
        req      = 3'b010;
        seg_data = DATA_A;
        push_window(10, 3'b000);
        for (int i = 1; i <= 10; i++) begin
            step_check("pre_rst");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_pins("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();

        // Scan restarts at digit 0; equal-cycle requests resolve by index.
        run_frame("r_idle",  3'b000, DATA_A, 3'b000, DATA_A, 3'b000);
        run_frame("r_tie",   3'b101, DATA_A, 3'b101, DATA_A, 3'b001);
        run_frame("r_show",  3'b101, DATA_A, 3'b101, DATA_A, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
